// File: rtl/pmu_edge_timing_monitor_pkg.sv
// Shared types for the PMU edge-to-edge timing monitor: channel FSM states,
// edge polarity encodings and verdict codes.
package pmu_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TIMING
    } state_t;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    typedef enum logic [1:0] {
        V_NONE,
        V_PASS,
        V_FAIL
    } verdict_t;

endpackage

// File: rtl/pmu_edge_timing_monitor_if.sv
// Configuration and status bundle of the edge timing monitor; channel fields
// are packed flat vectors, channel i in slice i.
interface pmu_edge_timing_monitor_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned STAT_W = 8
);
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH-1:0]        a_sig;
    logic [NUM_CH-1:0]        b_sig;
    logic [NUM_CH-1:0]        a_pol;
    logic [NUM_CH-1:0]        b_pol;
    logic [NUM_CH*CNT_W-1:0]  min_cyc;
    logic [NUM_CH*CNT_W-1:0]  max_cyc;
    logic                     clr_stats;
    logic [NUM_CH-1:0]        busy;
    logic [NUM_CH-1:0]        err_pulse;
    logic [NUM_CH-1:0]        err_sticky;
    logic [NUM_CH*STAT_W-1:0] pass_cnt;
    logic [NUM_CH*STAT_W-1:0] fail_cnt;

    modport master (
        output ch_en, a_sig, b_sig, a_pol, b_pol, min_cyc, max_cyc, clr_stats,
        input  busy, err_pulse, err_sticky, pass_cnt, fail_cnt
    );

    modport slave (
        input  ch_en, a_sig, b_sig, a_pol, b_pol, min_cyc, max_cyc, clr_stats,
        output busy, err_pulse, err_sticky, pass_cnt, fail_cnt
    );
endinterface

// File: rtl/pmu_edge_timing_monitor_chan.sv
// One monitor channel: input synchronisers, edge detection, timing FSM with
// interval counter, and saturating pass/fail statistics.
module pmu_edge_chan
    import pmu_mon_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STAT_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ch_en,
    input  logic              a_sig,
    input  logic              b_sig,
    input  logic              a_pol,
    input  logic              b_pol,
    input  logic [CNT_W-1:0]  min_cyc,
    input  logic [CNT_W-1:0]  max_cyc,
    input  logic              clr_stats,
    output logic              busy,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [STAT_W-1:0] pass_cnt,
    output logic [STAT_W-1:0] fail_cnt
);

    logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
    logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
    logic                   a_dly_q, a_dly_d;
    logic                   b_dly_q, b_dly_d;
    logic                   a_s, b_s, a_edge, b_edge;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STAT_W-1:0]      pass_cnt_q, pass_cnt_d;
    logic [STAT_W-1:0]      fail_cnt_q, fail_cnt_d;
    logic                   err_pulse_q, err_pulse_d;
    logic                   err_sticky_q, err_sticky_d;

    verdict_t               v_b, v_a;
    logic                   settle_ok, window_ok;
    logic                   pass_inc;
    logic [1:0]             fail_n;
    logic [STAT_W:0]        pass_sum, fail_sum;

    // Both paths see the same latency, so the delayed copy keeps intervals exact.
    always_comb begin
        a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a_sig};
        b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b_sig};
        a_s      = a_sync_q[SYNC_STAGES-1];
        b_s      = b_sync_q[SYNC_STAGES-1];
        a_dly_d  = a_s;
        b_dly_d  = b_s;
        a_edge   = (a_pol == EDGE_RISE) ? (a_s & ~a_dly_q) : (~a_s & a_dly_q);
        b_edge   = (b_pol == EDGE_RISE) ? (b_s & ~b_dly_q) : (~b_s & b_dly_q);
    end

    assign settle_ok = (b_s == b_pol);
    assign window_ok = (cnt_q > min_cyc) && ((max_cyc == '0) || (cnt_q <= max_cyc));

    // v_b carries the interval verdict, v_a the settle verdict; both can fire together.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_b     = V_NONE;
        v_a     = V_NONE;
        if (!ch_en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (a_edge) begin
                        if (settle_ok) begin
                            state_d = TIMING;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            v_a = V_FAIL;
                        end
                    end
                end
                TIMING: begin
                    if (b_edge) begin
                        v_b     = window_ok ? V_PASS : V_FAIL;
                        state_d = ARMED;
                        cnt_d   = '0;
                        if (a_edge) begin
                            if (settle_ok) begin
                                state_d = TIMING;
                                cnt_d   = CNT_W'(1);
                            end else begin
                                v_a = V_FAIL;
                            end
                        end
                    end else if (a_edge) begin
                        cnt_d = CNT_W'(1);
                    end else if ((max_cyc != '0) && (cnt_q == max_cyc)) begin
                        v_b     = V_FAIL;
                        state_d = ARMED;
                        cnt_d   = '0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pass_inc     = (v_b == V_PASS);
        fail_n       = {1'b0, v_b == V_FAIL} + {1'b0, v_a == V_FAIL};
        pass_sum     = {1'b0, pass_cnt_q} + {{STAT_W{1'b0}}, pass_inc};
        fail_sum     = {1'b0, fail_cnt_q} + {{(STAT_W-1){1'b0}}, fail_n};
        err_pulse_d  = (fail_n != 2'd0);
        pass_cnt_d   = pass_sum[STAT_W] ? '1 : pass_sum[STAT_W-1:0];
        fail_cnt_d   = fail_sum[STAT_W] ? '1 : fail_sum[STAT_W-1:0];
        err_sticky_d = err_sticky_q | err_pulse_d;
        if (clr_stats) begin
            pass_cnt_d   = '0;
            fail_cnt_d   = '0;
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sync_q     <= '0;
            b_sync_q     <= '0;
            a_dly_q      <= 1'b0;
            b_dly_q      <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            a_sync_q     <= a_sync_d;
            b_sync_q     <= b_sync_d;
            a_dly_q      <= a_dly_d;
            b_dly_q      <= b_dly_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign busy       = (state_q == TIMING);
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;

endmodule

// File: rtl/pmu_edge_timing_monitor.sv
// Multi-channel PMU edge-to-edge timing monitor: slices the bundled vectors
// per channel and fans clr_stats out to every channel.
module pmu_edge_timing_monitor
    import pmu_mon_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STAT_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                     C_clk,
    input logic                     C_purstb,
    pmu_edge_timing_monitor_if.slave mon
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pmu_edge_chan #(
            .CNT_W      (CNT_W),
            .STAT_W     (STAT_W),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clk       (C_clk),
            .rst_n     (C_purstb),
            .ch_en     (mon.ch_en[i]),
            .a_sig     (mon.a_sig[i]),
            .b_sig     (mon.b_sig[i]),
            .a_pol     (mon.a_pol[i]),
            .b_pol     (mon.b_pol[i]),
            .min_cyc   (mon.min_cyc[i*CNT_W +: CNT_W]),
            .max_cyc   (mon.max_cyc[i*CNT_W +: CNT_W]),
            .clr_stats (mon.clr_stats),
            .busy      (mon.busy[i]),
            .err_pulse (mon.err_pulse[i]),
            .err_sticky(mon.err_sticky[i]),
            .pass_cnt  (mon.pass_cnt[i*STAT_W +: STAT_W]),
            .fail_cnt  (mon.fail_cnt[i*STAT_W +: STAT_W])
        );
    end

endmodule

// File: tb/tb_pmu_edge_timing_monitor.sv
// Directed bench for the edge timing monitor: stimulus driven on the falling
// clock edge, outputs sampled on the falling edge after the update.
module tb_pmu_edge_timing_monitor;

    logic C_clk;
    logic C_purstb;
    int   checks;
    int   errors;

    pmu_edge_timing_monitor_if #(.NUM_CH(4), .CNT_W(16), .STAT_W(8)) mon ();

    pmu_edge_timing_monitor #(
        .NUM_CH     (4),
        .CNT_W      (16),
        .STAT_W     (8),
        .SYNC_STAGES(2)
    ) dut (
        .C_clk   (C_clk),
        .C_purstb(C_purstb),
        .mon     (mon)
    );

    initial C_clk = 1'b0;
    always #5 C_clk = ~C_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge C_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        C_purstb      = 1'b0;
        mon.ch_en     = '0;
        mon.a_sig     = '0;
        mon.b_sig     = 4'b0010;
        mon.a_pol     = 4'b0000;
        mon.b_pol     = 4'b0011;
        mon.min_cyc   = {16'd5, 16'd0, 16'd2, 16'd100};
        mon.max_cyc   = {16'd0, 16'd50, 16'd0, 16'd300};
        mon.clr_stats = 1'b0;

        tick(3);
        chk("rst_busy",   32'(mon.busy),       32'h0);
        chk("rst_sticky", 32'(mon.err_sticky), 32'h0);
        chk("rst_pulse",  32'(mon.err_pulse),  32'h0);
        chk("rst_pass",   32'(mon.pass_cnt),   32'h0);
        chk("rst_fail",   32'(mon.fail_cnt),   32'h0);
        C_purstb  = 1'b1;
        mon.ch_en = 4'hF;
        tick(5);

        // ch0: A and B are the same wire, A rising / B falling
        mon.a_sig[0] = 1'b1; mon.b_sig[0] = 1'b1;
        tick(150);
        mon.a_sig[0] = 1'b0; mon.b_sig[0] = 1'b0;
        tick(6);
        chk("ch0_pass", 32'(mon.pass_cnt[7:0]), 32'd1);
        chk("ch0_fail0", 32'(mon.fail_cnt[7:0]), 32'd0);
        mon.a_sig[0] = 1'b1; mon.b_sig[0] = 1'b1;
        tick(302);
        chk("ch0_pulse_pre", 32'(mon.err_pulse[0]), 32'd0);
        tick(1);
        chk("ch0_pulse", 32'(mon.err_pulse[0]), 32'd1);
        chk("ch0_sticky", 32'(mon.err_sticky[0]), 32'd1);
        tick(1);
        chk("ch0_pulse_post", 32'(mon.err_pulse[0]), 32'd0);
        tick(196);
        mon.a_sig[0] = 1'b0; mon.b_sig[0] = 1'b0;
        tick(6);
        chk("ch0_fail1", 32'(mon.fail_cnt[7:0]), 32'd1);
        chk("ch0_pass1", 32'(mon.pass_cnt[7:0]), 32'd1);

        // ch1: measured 3 > 2 passes, measured 1 fails, B pre-low is settle fail
        mon.a_sig[1] = 1'b1;
        tick(3);
        mon.b_sig[1] = 1'b0;
        tick(6);
        chk("ch1_pass", 32'(mon.pass_cnt[15:8]), 32'd1);
        mon.a_sig[1] = 1'b0; mon.b_sig[1] = 1'b1;
        tick(4);
        mon.a_sig[1] = 1'b1;
        tick(1);
        mon.b_sig[1] = 1'b0;
        tick(6);
        chk("ch1_short", 32'(mon.fail_cnt[15:8]), 32'd1);
        mon.a_sig[1] = 1'b0;
        tick(4);
        mon.a_sig[1] = 1'b1;
        tick(4);
        chk("ch1_settle", 32'(mon.fail_cnt[15:8]), 32'd2);
        chk("ch1_armed", 32'(mon.busy[1]), 32'd0);

        // ch1: A and B edges together in TIMING -> pass (6) then settle fail
        mon.a_sig[1] = 1'b0; mon.b_sig[1] = 1'b1;
        tick(4);
        mon.a_sig[1] = 1'b1;
        tick(3);
        mon.a_sig[1] = 1'b0;
        tick(3);
        mon.a_sig[1] = 1'b1; mon.b_sig[1] = 1'b0;
        tick(6);
        chk("ch1_same_pass", 32'(mon.pass_cnt[15:8]), 32'd2);
        chk("ch1_same_fail", 32'(mon.fail_cnt[15:8]), 32'd3);
        chk("ch1_same_busy", 32'(mon.busy[1]), 32'd0);

        // ch1: second A edge restarts, so B after 2 more cycles measures 2 (fail)
        mon.a_sig[1] = 1'b0; mon.b_sig[1] = 1'b1;
        tick(4);
        mon.a_sig[1] = 1'b1;
        tick(10);
        mon.a_sig[1] = 1'b0;
        tick(2);
        mon.a_sig[1] = 1'b1;
        tick(2);
        mon.b_sig[1] = 1'b0;
        tick(6);
        chk("ch1_restart_fail", 32'(mon.fail_cnt[15:8]), 32'd4);
        chk("ch1_restart_pass", 32'(mon.pass_cnt[15:8]), 32'd2);

        // ch2: timeout at cnt==50 with B never toggling
        mon.a_sig[2] = 1'b1;
        tick(52);
        chk("ch2_pulse_pre", 32'(mon.err_pulse[2]), 32'd0);
        chk("ch2_busy_pre", 32'(mon.busy[2]), 32'd1);
        tick(1);
        chk("ch2_pulse", 32'(mon.err_pulse[2]), 32'd1);
        chk("ch2_busy_drop", 32'(mon.busy[2]), 32'd0);
        chk("ch2_fail", 32'(mon.fail_cnt[23:16]), 32'd1);
        tick(1);
        chk("ch2_pulse_post", 32'(mon.err_pulse[2]), 32'd0);

        // ch3: disable mid-TIMING, no verdict; then a normal pass
        mon.a_sig[3] = 1'b1;
        tick(22);
        mon.ch_en[3] = 1'b0;
        tick(1);
        chk("ch3_dis_busy", 32'(mon.busy[3]), 32'd0);
        tick(3);
        chk("ch3_dis_sticky", 32'(mon.err_sticky[3]), 32'd0);
        chk("ch3_dis_pass", 32'(mon.pass_cnt[31:24]), 32'd0);
        chk("ch3_dis_fail", 32'(mon.fail_cnt[31:24]), 32'd0);
        mon.a_sig[3] = 1'b0;
        tick(3);
        mon.ch_en[3] = 1'b1;
        tick(3);
        mon.a_sig[3] = 1'b1;
        tick(10);
        mon.b_sig[3] = 1'b1;
        tick(6);
        chk("ch3_reen_pass", 32'(mon.pass_cnt[31:24]), 32'd1);
        mon.a_sig[3] = 1'b0; mon.b_sig[3] = 1'b0;
        tick(3);

        // ch3: 300 passing pulses saturate pass_cnt
        for (int i = 0; i < 300; i++) begin
            mon.a_sig[3] = 1'b1;
            tick(8);
            mon.b_sig[3] = 1'b1;
            tick(2);
            mon.a_sig[3] = 1'b0; mon.b_sig[3] = 1'b0;
            tick(3);
        end
        tick(4);
        chk("ch3_sat", 32'(mon.pass_cnt[31:24]), 32'd255);
        chk("ch3_sat_fail", 32'(mon.fail_cnt[31:24]), 32'd0);

        // ch3: settle fail, then clr_stats coincident with a second settle fail
        mon.b_sig[3] = 1'b1;
        tick(4);
        mon.a_sig[3] = 1'b1;
        tick(4);
        chk("ch3_sfail", 32'(mon.fail_cnt[31:24]), 32'd1);
        chk("ch3_ssticky", 32'(mon.err_sticky[3]), 32'd1);
        mon.a_sig[3] = 1'b0;
        tick(4);
        mon.a_sig[3] = 1'b1;
        tick(2);
        mon.clr_stats = 1'b1;
        tick(1);
        mon.clr_stats = 1'b0;
        chk("clr_fail", 32'(mon.fail_cnt[31:24]), 32'd0);
        chk("clr_sticky", 32'(mon.err_sticky[3]), 32'd0);
        chk("clr_pulse", 32'(mon.err_pulse[3]), 32'd1);
        chk("clr_pass", 32'(mon.pass_cnt[31:24]), 32'd0);
        chk("clr_fanout", 32'(mon.pass_cnt[15:8]), 32'd0);
        mon.a_sig[3] = 1'b0; mon.b_sig[3] = 1'b0;

        // reset in the middle of a TIMING interval
        mon.a_sig[1] = 1'b0; mon.b_sig[1] = 1'b1;
        tick(4);
        mon.a_sig[1] = 1'b1;
        tick(5);
        mon.b_sig[1] = 1'b0;
        tick(6);
        chk("pre_rst_pass1", 32'(mon.pass_cnt[15:8]), 32'd1);
        mon.a_sig[2] = 1'b0;
        tick(4);
        mon.a_sig[2] = 1'b1;
        tick(10);
        chk("pre_rst_busy2", 32'(mon.busy[2]), 32'd1);
        C_purstb = 1'b0;
        tick(1);
        C_purstb = 1'b1;
        chk("mid_rst_busy", 32'(mon.busy), 32'h0);
        chk("mid_rst_pulse", 32'(mon.err_pulse), 32'h0);
        chk("mid_rst_sticky", 32'(mon.err_sticky), 32'h0);
        chk("mid_rst_pass", 32'(mon.pass_cnt), 32'h0);
        chk("mid_rst_fail", 32'(mon.fail_cnt), 32'h0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
